// File: rtl/ama_riscv_store_shift_mask.sv
`default_nettype none
// ============================================================================
// Module   : ama_riscv_store_shift_mask
// Purpose  : Store-side lane steering for the MEM stage. A store request is
//            shifted onto the byte lanes of a 32-bit DMEM word and issued as
//            one or two word-aligned write beats over a valid/ready handshake.
//            Each beat carries per-byte write enables.
// Ports    : clk, rst         - clock (rising edge), synchronous active-high reset
//            req_valid/ready  - store request handshake (ready only in IDLE)
//            req_addr         - byte address (AW bits)
//            req_width        - 0 byte, 1 half, 2 word, 3 illegal
//            req_data         - rs2 data; only the low bytes for the width are used
//            dmem_valid/ready - write beat handshake
//            dmem_addr        - word address (AW-2 bits)
//            dmem_we          - byte enables, bit i covers wdata[8i+7:8i]
//            dmem_wdata       - lane-aligned write data, unused lanes zero
//            store_fault      - one-cycle pulse when a request is dropped
//            busy             - high while a write is in flight
// Config   : AMA_RISCV_MISALIGNED_SPLIT_EN - when defined, stores that cross
//            a word boundary issue a second beat. When undefined, they are
//            dropped and reported on store_fault.
// Revision : 1.0 - initial release
// ============================================================================
module ama_riscv_store_shift_mask #(
  parameter int AW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [AW-1:0] req_addr,
  input  logic [1:0]    req_width,
  input  logic [31:0]   req_data,
  output logic          dmem_valid,
  input  logic          dmem_ready,
  output logic [AW-3:0] dmem_addr,
  output logic [3:0]    dmem_we,
  output logic [31:0]   dmem_wdata,
  output logic          store_fault,
  output logic          busy
);

  localparam logic [1:0] C_WIDTH_ILLEGAL = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WR_LO = 2'd1
`ifdef AMA_RISCV_MISALIGNED_SPLIT_EN
    ,
    WR_HI = 2'd2
`endif
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;

  logic          r_dmem_valid;
  logic [AW-3:0] r_dmem_addr;
  logic [3:0]    r_dmem_we;
  logic [31:0]   r_dmem_wdata;
  logic          r_store_fault;

  logic          w_dmem_valid_nxt;
  logic [AW-3:0] w_dmem_addr_nxt;
  logic [3:0]    w_dmem_we_nxt;
  logic [31:0]   w_dmem_wdata_nxt;
  logic          w_store_fault_nxt;

  // Lane math, evaluated on the incoming request
  logic [1:0]    w_off;
  logic [3:0]    w_bytemask;
  logic [7:0]    w_m8;
  logic [31:0]   w_data_masked;
  logic          w_split;
  logic [AW-3:0] w_lo_addr;
  logic [3:0]    w_lo_we;
  logic [31:0]   w_lo_wdata;

`ifdef AMA_RISCV_MISALIGNED_SPLIT_EN
  logic [63:0]   w_d64;
  logic [AW-3:0] w_hi_addr;
  logic [AW-3:0] r_hi_addr;
  logic [3:0]    r_hi_we;
  logic [31:0]   r_hi_wdata;
  logic          r_split;
  logic [AW-3:0] w_hi_addr_nxt;
  logic [3:0]    w_hi_we_nxt;
  logic [31:0]   w_hi_wdata_nxt;
  logic          w_split_nxt;
`endif

  always_comb begin
    w_off = req_addr[1:0];
    case (req_width)
      2'd0:    w_bytemask = 4'b0001;
      2'd1:    w_bytemask = 4'b0011;
      2'd2:    w_bytemask = 4'b1111;
      default: w_bytemask = 4'b0000;
    endcase
    w_m8          = {4'b0000, w_bytemask} << w_off;
    w_data_masked = req_data & {{8{w_bytemask[3]}}, {8{w_bytemask[2]}},
                                {8{w_bytemask[1]}}, {8{w_bytemask[0]}}};
    // Any enable pushed past lane 3 means the store crosses into the next word
    w_split   = |w_m8[7:4];
    w_lo_addr = req_addr[AW-1:2];
    w_lo_we   = w_m8[3:0];
`ifdef AMA_RISCV_MISALIGNED_SPLIT_EN
    w_d64      = {32'b0, w_data_masked} << {w_off, 3'b000};
    w_lo_wdata = w_d64[31:0];
    // Word address wraps naturally at the top of the AW-2 bit space
    w_hi_addr  = w_lo_addr + {{(AW-3){1'b0}}, 1'b1};
`else
    w_lo_wdata = w_data_masked << {w_off, 3'b000};
`endif
  end

  always_comb begin
    w_state_nxt       = r_state;
    w_dmem_valid_nxt  = r_dmem_valid;
    w_dmem_addr_nxt   = r_dmem_addr;
    w_dmem_we_nxt     = r_dmem_we;
    w_dmem_wdata_nxt  = r_dmem_wdata;
    w_store_fault_nxt = 1'b0;
`ifdef AMA_RISCV_MISALIGNED_SPLIT_EN
    w_hi_addr_nxt     = r_hi_addr;
    w_hi_we_nxt       = r_hi_we;
    w_hi_wdata_nxt    = r_hi_wdata;
    w_split_nxt       = r_split;
`endif

    case (r_state)
      IDLE: begin
        if (req_valid) begin
          if (req_width == C_WIDTH_ILLEGAL) begin
            w_store_fault_nxt = 1'b1;
          end
`ifndef AMA_RISCV_MISALIGNED_SPLIT_EN
          else if (w_split) begin
            w_store_fault_nxt = 1'b1;
          end
`endif
          else begin
            w_dmem_valid_nxt = 1'b1;
            w_dmem_addr_nxt  = w_lo_addr;
            w_dmem_we_nxt    = w_lo_we;
            w_dmem_wdata_nxt = w_lo_wdata;
            w_state_nxt      = WR_LO;
`ifdef AMA_RISCV_MISALIGNED_SPLIT_EN
            w_hi_addr_nxt    = w_hi_addr;
            w_hi_we_nxt      = w_m8[7:4];
            w_hi_wdata_nxt   = w_d64[63:32];
            w_split_nxt      = w_split;
`endif
          end
        end
      end

      WR_LO: begin
        if (dmem_ready) begin
`ifdef AMA_RISCV_MISALIGNED_SPLIT_EN
          if (r_split) begin
            // Second beat replaces the first with no idle cycle between them
            w_dmem_addr_nxt  = r_hi_addr;
            w_dmem_we_nxt    = r_hi_we;
            w_dmem_wdata_nxt = r_hi_wdata;
            w_state_nxt      = WR_HI;
          end else
`endif
          begin
            w_dmem_valid_nxt = 1'b0;
            w_dmem_we_nxt    = 4'b0000;
            w_state_nxt      = IDLE;
          end
        end
      end

`ifdef AMA_RISCV_MISALIGNED_SPLIT_EN
      WR_HI: begin
        if (dmem_ready) begin
          w_dmem_valid_nxt = 1'b0;
          w_dmem_we_nxt    = 4'b0000;
          w_state_nxt      = IDLE;
        end
      end
`endif

      default: begin
        w_dmem_valid_nxt = 1'b0;
        w_dmem_we_nxt    = 4'b0000;
        w_state_nxt      = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= IDLE;
      r_dmem_valid  <= 1'b0;
      r_dmem_addr   <= '0;
      r_dmem_we     <= 4'b0000;
      r_dmem_wdata  <= 32'h0;
      r_store_fault <= 1'b0;
`ifdef AMA_RISCV_MISALIGNED_SPLIT_EN
      r_hi_addr     <= '0;
      r_hi_we       <= 4'b0000;
      r_hi_wdata    <= 32'h0;
      r_split       <= 1'b0;
`endif
    end else begin
      r_state       <= w_state_nxt;
      r_dmem_valid  <= w_dmem_valid_nxt;
      r_dmem_addr   <= w_dmem_addr_nxt;
      r_dmem_we     <= w_dmem_we_nxt;
      r_dmem_wdata  <= w_dmem_wdata_nxt;
      r_store_fault <= w_store_fault_nxt;
`ifdef AMA_RISCV_MISALIGNED_SPLIT_EN
      r_hi_addr     <= w_hi_addr_nxt;
      r_hi_we       <= w_hi_we_nxt;
      r_hi_wdata    <= w_hi_wdata_nxt;
      r_split       <= w_split_nxt;
`endif
    end
  end

  assign req_ready   = (r_state == IDLE);
  assign busy        = (r_state != IDLE);
  assign dmem_valid  = r_dmem_valid;
  assign dmem_addr   = r_dmem_addr;
  assign dmem_we     = r_dmem_we;
  assign dmem_wdata  = r_dmem_wdata;
  assign store_fault = r_store_fault;

endmodule
`default_nettype wire

// File: tb/tb_ama_riscv_store_shift_mask.sv
`default_nettype none
// ============================================================================
// Module   : tb_ama_riscv_store_shift_mask
// Purpose  : Self-checking bench for ama_riscv_store_shift_mask. Expected
//            beats come from a byte-by-byte model: every stored byte goes to
//            byte address addr+i, and bytes are grouped by word address.
// Config   : follows AMA_RISCV_MISALIGNED_SPLIT_EN like the design
// Revision : 1.0 - initial release
// ============================================================================
module tb_ama_riscv_store_shift_mask;

  localparam int AW = 32;
`ifdef AMA_RISCV_MISALIGNED_SPLIT_EN
  localparam bit SPLIT_EN = 1'b1;
`else
  localparam bit SPLIT_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic [AW-1:0] req_addr;
  logic [1:0]    req_width;
  logic [31:0]   req_data;
  logic          dmem_valid;
  logic          dmem_ready;
  logic [AW-3:0] dmem_addr;
  logic [3:0]    dmem_we;
  logic [31:0]   dmem_wdata;
  logic          store_fault;
  logic          busy;

  int checks = 0;
  int errors = 0;

  ama_riscv_store_shift_mask #(.AW(AW)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_addr    (req_addr),
    .req_width   (req_width),
    .req_data    (req_data),
    .dmem_valid  (dmem_valid),
    .dmem_ready  (dmem_ready),
    .dmem_addr   (dmem_addr),
    .dmem_we     (dmem_we),
    .dmem_wdata  (dmem_wdata),
    .store_fault (store_fault),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  // Issues one store from IDLE (called at a negedge) and follows it to the
  // end, checking every cycle against the byte-level model.
  task automatic run_store(input logic [31:0] addr, input logic [1:0] width,
                           input logic [31:0] data, input int stall0,
                           input int stall1, input string tag);
    logic [3:0]  we_e [2];
    logic [31:0] wd_e [2];
    logic [29:0] wa_e [2];
    logic [31:0] ba;
    int          nb;
    int          nbeats;
    int          lane;
    int          s;
    bit          fault_e;

    we_e[0] = 4'h0; we_e[1] = 4'h0;
    wd_e[0] = 32'h0; wd_e[1] = 32'h0;
    wa_e[0] = addr[31:2]; wa_e[1] = 30'h0;
    fault_e = (width == 2'd3);
    nb = fault_e ? 0 : (1 << width);
    for (int i = 0; i < nb; i++) begin
      ba   = addr + i;
      lane = int'(ba[1:0]);
      if (ba[31:2] == wa_e[0]) begin
        we_e[0][lane] = 1'b1;
        wd_e[0][8*lane +: 8] = data[8*i +: 8];
      end else begin
        wa_e[1] = ba[31:2];
        we_e[1][lane] = 1'b1;
        wd_e[1][8*lane +: 8] = data[8*i +: 8];
      end
    end
    nbeats = (we_e[1] != 4'h0) ? 2 : 1;
    if (nbeats == 2 && !SPLIT_EN) fault_e = 1'b1;

    checks++;
    if (req_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s idle_before ready=%b busy=%b required 1/0", tag, req_ready, busy);
    end
    req_valid = 1'b1; req_addr = addr; req_width = width; req_data = data;
    dmem_ready = 1'b1;
    @(negedge clk);

    if (fault_e) begin
      req_valid = 1'b0;
      checks++;
      if (store_fault !== 1'b1 || dmem_valid !== 1'b0 || busy !== 1'b0 || req_ready !== 1'b1) begin
        errors++;
        $display("FAIL %s fault_pulse fault=%b valid=%b busy=%b ready=%b required 1/0/0/1",
                 tag, store_fault, dmem_valid, busy, req_ready);
      end
      @(negedge clk);
      checks++;
      if (store_fault !== 1'b0 || dmem_valid !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL %s fault_end fault=%b valid=%b busy=%b required 0/0/0",
                 tag, store_fault, dmem_valid, busy);
      end
    end else begin
      // Garbage held on the request port while busy must be ignored
      req_addr = $urandom; req_width = 2'($urandom_range(0, 3)); req_data = $urandom;
      for (int b = 0; b < nbeats; b++) begin
        s = (b == 0) ? stall0 : stall1;
        for (int k = 0; k <= s; k++) begin
          dmem_ready = (k == s);
          checks++;
          if (dmem_valid !== 1'b1 || busy !== 1'b1 || req_ready !== 1'b0 || store_fault !== 1'b0) begin
            errors++;
            $display("FAIL %s beat%0d_ctrl cyc%0d valid=%b busy=%b ready=%b fault=%b required 1/1/0/0",
                     tag, b, k, dmem_valid, busy, req_ready, store_fault);
          end
          checks++;
          if ({dmem_addr, dmem_we, dmem_wdata} !== {wa_e[b], we_e[b], wd_e[b]}) begin
            errors++;
            $display("FAIL %s beat%0d_data cyc%0d addr=%h we=%b wdata=%h required addr=%h we=%b wdata=%h",
                     tag, b, k, dmem_addr, dmem_we, dmem_wdata, wa_e[b], we_e[b], wd_e[b]);
          end
          @(negedge clk);
        end
      end
      req_valid = 1'b0;
      dmem_ready = 1'b0;
      checks++;
      if (dmem_valid !== 1'b0 || dmem_we !== 4'h0 || req_ready !== 1'b1 || busy !== 1'b0) begin
        errors++;
        $display("FAIL %s done valid=%b we=%b ready=%b busy=%b required 0/0000/1/0",
                 tag, dmem_valid, dmem_we, req_ready, busy);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 1'b0; req_addr = '0; req_width = 2'd0; req_data = 32'h0;
    dmem_ready = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({dmem_valid, dmem_addr, dmem_we, dmem_wdata, store_fault, busy, req_ready} !==
        {1'b0, 30'h0, 4'h0, 32'h0, 1'b0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL reset_state valid=%b addr=%h we=%b wdata=%h fault=%b busy=%b ready=%b required all 0, ready 1",
               dmem_valid, dmem_addr, dmem_we, dmem_wdata, store_fault, busy, req_ready);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (dmem_valid !== 1'b0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release valid=%b ready=%b required 0/1", dmem_valid, req_ready);
    end
  endtask

  task automatic test_byte_store();
    run_store(32'h0000_0103, 2'd0, 32'hDEAD_BEEF, 0, 0, "byte_off3");
    run_store(32'h0000_0200, 2'd0, 32'h1234_5678, 1, 0, "byte_off0");
  endtask

  task automatic test_half_stall();
    run_store(32'h0000_0022, 2'd1, 32'h1234_ABCD, 3, 0, "half_off2_stall");
    run_store(32'h0000_0031, 2'd1, 32'hFFFF_5AA5, 0, 0, "half_off1");
  endtask

  task automatic test_misaligned_word();
    run_store(32'h0000_0007, 2'd2, 32'h1122_3344, 0, 0, "word_off3");
    run_store(32'hFFFF_FFFF, 2'd2, 32'h1122_3344, 0, 1, "word_wrap");
    run_store(32'h0000_0013, 2'd1, 32'hCAFE_F00D, 1, 2, "half_off3");
  endtask

  task automatic test_illegal_width();
    run_store(32'h0000_0000, 2'd3, 32'hAAAA_5555, 0, 0, "illegal");
    run_store(32'h0000_0008, 2'd2, 32'h8765_4321, 0, 0, "word_after_illegal");
  endtask

  task automatic test_random();
    for (int n = 0; n < 60; n++) begin
      run_store($urandom, 2'($urandom_range(0, 3)), $urandom,
                $urandom_range(0, 2), $urandom_range(0, 2), "random");
    end
  endtask

  task automatic test_reset_mid_split();
    req_valid = 1'b1; req_width = 2'd2; req_data = 32'h1122_3344;
`ifdef AMA_RISCV_MISALIGNED_SPLIT_EN
    req_addr = 32'h0000_0007;
    dmem_ready = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (dmem_valid !== 1'b1 || dmem_we !== 4'b0111) begin
      errors++;
      $display("FAIL rst_mid_hi_setup valid=%b we=%b required 1/0111", dmem_valid, dmem_we);
    end
`else
    req_addr = 32'h0000_0040;
    dmem_ready = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    checks++;
    if (dmem_valid !== 1'b1 || dmem_we !== 4'hF) begin
      errors++;
      $display("FAIL rst_mid_lo_setup valid=%b we=%b required 1/1111", dmem_valid, dmem_we);
    end
`endif
    dmem_ready = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({dmem_valid, dmem_addr, dmem_we, dmem_wdata, busy, req_ready} !==
        {1'b0, 30'h0, 4'h0, 32'h0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL rst_mid_abort valid=%b addr=%h we=%b wdata=%h busy=%b ready=%b required 0/0/0/0/0/1",
               dmem_valid, dmem_addr, dmem_we, dmem_wdata, busy, req_ready);
    end
    rst = 1'b0;
    dmem_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (dmem_valid !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL rst_mid_no_beat cyc%0d valid=%b busy=%b required 0/0", k, dmem_valid, busy);
      end
    end
    dmem_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_byte_store();
    test_half_stall();
    test_misaligned_word();
    test_illegal_width();
    test_random();
    test_reset_mid_split();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
